dualram_burst_arbiter: RTL and testbench

- Shares one port of the JPEG SoC dual-port data RAM between two requesters: port 0 is the CPU load/store path and port 1 is the JPEG encoder engine.
- Each request is a burst of 1..2^LENW words; the arbiter increments the word address by 1 per beat.
- Bursts are granted round-robin. Every beat's address is checked against the RAM window and the two system-control words.
- Sits between the requesters and one RAM port. The RAM read is combinational, the RAM write is on the clock edge, and both share the arbiter clock.

---
 rtl/dualram_burst_arbiter.sv | 153 +++++++++++++++
 tb/tb_dualram_burst_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dualram_burst_arbiter.sv
// Round-robin burst arbiter sharing one port of the JPEG SoC data RAM between
// the CPU (requester 0) and the JPEG encoder (requester 1).
module dualram_burst_arbiter #(
    parameter int WIDTH = 32,
    parameter int BASE  = 206800,
    parameter int DEPTH = 1200,
    parameter int CTRL0 = 411698,
    parameter int CTRL1 = 411699,
    parameter int LENW  = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             req0,
    input  logic             we0,
    input  logic [WIDTH-1:0] addr0,
    input  logic [LENW-1:0]  len0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             gnt0,
    output logic             rvalid0,
    output logic [WIDTH-1:0] rdata0,
    output logic             err0,
    output logic             done0,
    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr1,
    input  logic [LENW-1:0]  len1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata1,
    output logic             err1,
    output logic             done1,
    output logic [WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_enw,
    input  logic [WIDTH-1:0] ram_rdata
);

    localparam logic [WIDTH-1:0] BASE_A  = WIDTH'(BASE);
    localparam logic [WIDTH-1:0] DEPTH_A = WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] CTRL0_A = WIDTH'(CTRL0);
    localparam logic [WIDTH-1:0] CTRL1_A = WIDTH'(CTRL1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic             owner;
    logic             ptr;
    logic             we_q;
    logic [WIDTH-1:0] addr_q;
    logic [LENW-1:0]  len_q;
    logic [LENW-1:0]  cnt;

    logic [1:0]       rvalid_p1;
    logic [1:0]       err_p1;
    logic [1:0]       done_p1;
    logic [WIDTH-1:0] rdata_p1 [2];

    logic             pick;
    logic             req_own;
    logic             beat;
    logic             in_window;
    logic             last;
    logic             wr_err;
    logic [WIDTH-1:0] wdata_own;

    // Unsigned wrap makes addresses below BASE land far above DEPTH.
    function automatic logic window_hit(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] off;
        off = a - BASE_A;
        return (off < DEPTH_A) || (a == CTRL0_A) || (a == CTRL1_A);
    endfunction

    assign pick      = (req0 && req1) ? ptr : req1;
    assign req_own   = owner ? req1 : req0;
    assign wdata_own = owner ? wdata1 : wdata0;
    assign beat      = (state == BURST) && req_own;
    assign in_window = window_hit(addr_q);
    assign last      = (cnt == len_q);
    assign wr_err    = beat && we_q && !in_window;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            owner       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt         <= '0;
            rvalid_p1   <= '0;
            err_p1      <= '0;
            done_p1     <= '0;
            rdata_p1[0] <= '0;
            rdata_p1[1] <= '0;
        end else begin
            rvalid_p1   <= '0;
            err_p1      <= '0;
            done_p1     <= '0;
            rdata_p1[0] <= '0;
            rdata_p1[1] <= '0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner  <= pick;
                        we_q   <= pick ? we1 : we0;
                        addr_q <= pick ? addr1 : addr0;
                        len_q  <= pick ? len1 : len0;
                        cnt    <= '0;
                        state  <= BURST;
                    end
                end
                BURST: begin
                    if (!req_own) begin
                        state <= IDLE;
                        ptr   <= ~owner;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        cnt    <= cnt + 1'b1;
                        // stage p1: read response one cycle after its beat
                        if (!we_q) begin
                            rvalid_p1[owner] <= 1'b1;
                            err_p1[owner]    <= !in_window;
                            rdata_p1[owner]  <= in_window ? ram_rdata : '0;
                        end
                        if (last) begin
                            done_p1[owner] <= 1'b1;
                            state          <= IDLE;
                            ptr            <= ~owner;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ram_addr  = beat ? addr_q : '0;
    assign ram_wdata = (beat && we_q) ? wdata_own : '0;
    assign ram_enw   = beat && we_q && in_window;

    assign gnt0    = beat && !owner;
    assign gnt1    = beat && owner;
    assign rvalid0 = rvalid_p1[0];
    assign rvalid1 = rvalid_p1[1];
    assign rdata0  = rdata_p1[0];
    assign rdata1  = rdata_p1[1];
    assign err0    = err_p1[0] || (wr_err && !owner);
    assign err1    = err_p1[1] || (wr_err && owner);
    assign done0   = done_p1[0];
    assign done1   = done_p1[1];

endmodule

// File: tb/tb_dualram_burst_arbiter.sv
// Scoreboard bench for dualram_burst_arbiter: directed bursts push cycle-stamped
// expected output snapshots; a negedge monitor pops and compares them.
module tb_dualram_burst_arbiter;

    typedef struct {
        int          cyc;
        logic [1:0]  gnt;
        logic [1:0]  rvalid;
        logic [1:0]  err;
        logic [1:0]  done;
        logic [31:0] rdata0;
        logic [31:0] rdata1;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        enw;
    } snap_t;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic [3:0]  len0 = 0, len1 = 0;
    logic        gnt0, rvalid0, err0, done0, gnt1, rvalid1, err1, done1;
    logic [31:0] rdata0, rdata1, ram_addr, ram_wdata, ram_rdata;
    logic        ram_enw;

    logic [31:0] mem [1200];
    logic [31:0] ctrl0 = 32'hC0DE_0000, ctrl1 = 32'hC0DE_0001;
    logic [31:0] wdv [8];
    logic [31:0] rdv [8];

    int    cyc = 0;
    int    checks = 0;
    int    fails = 0;
    snap_t expq[$];

    dualram_burst_arbiter dut (
        .clk(clk), .nreset(nreset),
        .req0(req0), .we0(we0), .addr0(addr0), .len0(len0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0), .done0(done0),
        .req1(req1), .we1(we1), .addr1(addr1), .len1(len1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1), .done1(done1),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_enw(ram_enw), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: combinational read, clocked write; junk outside the window
    always_comb begin
        logic [31:0] off;
        off = ram_addr - 32'd206800;
        if (off < 32'd1200)             ram_rdata = mem[off];
        else if (ram_addr == 32'd411698) ram_rdata = ctrl0;
        else if (ram_addr == 32'd411699) ram_rdata = ctrl1;
        else                             ram_rdata = 32'hBAD0_0000 ^ ram_addr;
    end

    always @(posedge clk) begin
        logic [31:0] woff;
        woff = ram_addr - 32'd206800;
        if (ram_enw) begin
            if (woff < 32'd1200)             mem[woff] <= ram_wdata;
            else if (ram_addr == 32'd411698) ctrl0 <= ram_wdata;
            else if (ram_addr == 32'd411699) ctrl1 <= ram_wdata;
        end
    end

    function automatic snap_t blank(input int c);
        snap_t s;
        s.cyc = c; s.gnt = 0; s.rvalid = 0; s.err = 0; s.done = 0;
        s.rdata0 = 0; s.rdata1 = 0; s.addr = 0; s.wdata = 0; s.wr = 0; s.enw = 0;
        return s;
    endfunction

    function automatic snap_t ev(input int c, input logic [1:0] g, input logic [1:0] rv,
                                 input logic [1:0] dn, input logic [31:0] a,
                                 input logic [31:0] r0, input logic [31:0] r1);
        snap_t s;
        s = blank(c);
        s.gnt = g; s.rvalid = rv; s.done = dn; s.addr = a; s.rdata0 = r0; s.rdata1 = r1;
        return s;
    endfunction

    function automatic logic active(input snap_t s);
        return (|s.gnt) || (|s.rvalid) || (|s.err) || (|s.done) || s.enw;
    endfunction

    always @(negedge clk) begin : monitor
        snap_t e;
        logic  ok;
        if (gnt0 || gnt1 || rvalid0 || rvalid1 || err0 || err1 || done0 || done1 || ram_enw) begin
            checks++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output cyc=%0d gnt=%b%b rvalid=%b%b err=%b%b done=%b%b enw=%b, required no activity",
                         cyc, gnt1, gnt0, rvalid1, rvalid0, err1, err0, done1, done0, ram_enw);
            end else begin
                e  = expq.pop_front();
                ok = (e.cyc == cyc) && (e.gnt == {gnt1, gnt0}) && (e.rvalid == {rvalid1, rvalid0})
                     && (e.err == {err1, err0}) && (e.done == {done1, done0}) && (e.enw == ram_enw);
                if (e.rvalid[0] && rdata0 !== e.rdata0) ok = 0;
                if (e.rvalid[1] && rdata1 !== e.rdata1) ok = 0;
                if ((|e.gnt) && ram_addr !== e.addr) ok = 0;
                if (e.wr && ram_wdata !== e.wdata) ok = 0;
                if (!ok) begin
                    fails++;
                    $display("FAIL scoreboard got cyc=%0d gnt=%b%b rv=%b%b err=%b%b done=%b%b rd0=%h rd1=%h addr=%0d wd=%h enw=%b; required cyc=%0d gnt=%b rv=%b err=%b done=%b rd0=%h rd1=%h addr=%0d wd=%h enw=%b",
                             cyc, gnt1, gnt0, rvalid1, rvalid0, err1, err0, done1, done0, rdata0, rdata1,
                             ram_addr, ram_wdata, ram_enw, e.cyc, e.gnt, e.rvalid, e.err, e.done,
                             e.rdata0, e.rdata1, e.addr, e.wdata, e.enw);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},    {30'd0, gnt1, gnt0}, 0);
        chk({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 0);
        chk({tag, "_err"},    {30'd0, err1, err0}, 0);
        chk({tag, "_done"},   {30'd0, done1, done0}, 0);
        chk({tag, "_rdata0"}, rdata0, 0);
        chk({tag, "_rdata1"}, rdata1, 0);
        chk({tag, "_ram"},    {31'd0, ram_enw} | ram_addr | ram_wdata, 0);
    endtask

    // Runs one burst on port p; abort_at >= 0 drops req after that many beats.
    task automatic burst(input int p, input logic w, input logic [31:0] a, input int len,
                         input logic [31:0] wd [8], input logic [31:0] rd [8],
                         input logic [7:0] er, input int abort_at);
        snap_t s [10];
        int    nb;
        int    c;
        @(posedge clk); #1;
        c  = cyc;
        nb = (abort_at >= 0) ? abort_at : len + 1;
        for (int j = 0; j <= nb; j++) s[j] = blank(c + 1 + j);
        for (int k = 0; k < nb; k++) begin
            s[k].gnt[p] = 1'b1;
            s[k].addr   = a + 32'(k);
            if (w) begin
                s[k].wr     = 1'b1;
                s[k].wdata  = wd[k];
                s[k].enw    = !er[k];
                s[k].err[p] = er[k];
            end else begin
                s[k+1].rvalid[p] = 1'b1;
                s[k+1].err[p]    = er[k];
                if (p == 0) s[k+1].rdata0 = rd[k];
                else        s[k+1].rdata1 = rd[k];
            end
        end
        if (abort_at < 0) s[nb].done[p] = 1'b1;
        for (int j = 0; j <= nb; j++) if (active(s[j])) expq.push_back(s[j]);
        if (p == 0) begin req0 = 1; we0 = w; addr0 = a; len0 = 4'(len); end
        else        begin req1 = 1; we1 = w; addr1 = a; len1 = 4'(len); end
        for (int k = 0; k < nb; k++) begin
            @(posedge clk); #1;
            if (p == 0) wdata0 = wd[k]; else wdata1 = wd[k];
        end
        @(posedge clk); #1;
        req0 = 0; we0 = 0; wdata0 = 0; req1 = 0; we1 = 0; wdata1 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        for (int i = 0; i < 1200; i++) mem[i] = 32'h5A00_0000 + 32'(i);
        mem[0] = 32'hDEAD_BEEF;

        // Reset with both requests already high
        req0 = 1; addr0 = 32'd206800; len0 = 4'd1;
        req1 = 1; addr1 = 32'd206820; len1 = 4'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");

        // Contention: 0, then 1, then 0, one IDLE cycle between bursts
        @(posedge clk); #1;
        nreset = 1;
        r = cyc;
        expq.push_back(ev(r+1, 2'b01, 2'b00, 2'b00, 32'd206800, 0, 0));
        expq.push_back(ev(r+2, 2'b01, 2'b01, 2'b00, 32'd206801, 32'hDEAD_BEEF, 0));
        expq.push_back(ev(r+3, 2'b00, 2'b01, 2'b01, 0, 32'h5A00_0001, 0));
        expq.push_back(ev(r+4, 2'b10, 2'b00, 2'b00, 32'd206820, 0, 0));
        expq.push_back(ev(r+5, 2'b10, 2'b10, 2'b00, 32'd206821, 0, 32'h5A00_0014));
        expq.push_back(ev(r+6, 2'b00, 2'b10, 2'b10, 0, 0, 32'h5A00_0015));
        expq.push_back(ev(r+7, 2'b01, 2'b00, 2'b00, 32'd206800, 0, 0));
        expq.push_back(ev(r+8, 2'b01, 2'b01, 2'b00, 32'd206801, 32'hDEAD_BEEF, 0));
        expq.push_back(ev(r+9, 2'b00, 2'b01, 2'b01, 0, 32'h5A00_0001, 0));
        repeat (9) @(posedge clk); #1;
        req0 = 0; req1 = 0;

        // Single read
        wdv = '{default: 32'd0};
        rdv = '{default: 32'd0};
        rdv[0] = 32'hDEAD_BEEF;
        burst(0, 1'b0, 32'd206800, 0, wdv, rdv, 8'h00, -1);

        // Write burst of four words on port 1, then read them back on port 0
        wdv = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
        burst(1, 1'b1, 32'd206810, 3, wdv, rdv, 8'h00, -1);
        rdv = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
        wdv = '{default: 32'd0};
        burst(0, 1'b0, 32'd206810, 3, wdv, rdv, 8'h00, -1);

        // Read across the window end: last two beats error with zero data
        rdv = '{32'h5A00_04AE, 32'h5A00_04AF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        burst(1, 1'b0, 32'd207998, 3, wdv, rdv, 8'b0000_1100, -1);

        // Control word 1 is readable
        rdv = '{32'hC0DE_0001, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        burst(0, 1'b0, 32'd411699, 0, wdv, rdv, 8'h00, -1);

        // Out-of-window write: gnt with err, no RAM write
        wdv = '{32'hFFFF_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        burst(1, 1'b1, 32'd208000, 0, wdv, rdv, 8'b0000_0001, -1);

        // Abort a len=7 read after two beats: two rvalids, no done
        wdv = '{default: 32'd0};
        rdv = '{32'hDEAD_BEEF, 32'h5A00_0001, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        burst(0, 1'b0, 32'd206800, 7, wdv, rdv, 8'h00, 2);

        // Pointer flipped by the abort: simultaneous requests go to 1 first
        @(posedge clk); #1;
        r = cyc;
        req0 = 1; addr0 = 32'd206800; len0 = 0;
        req1 = 1; addr1 = 32'd206801; len1 = 0;
        expq.push_back(ev(r+1, 2'b10, 2'b00, 2'b00, 32'd206801, 0, 0));
        expq.push_back(ev(r+2, 2'b00, 2'b10, 2'b10, 0, 0, 32'h5A00_0001));
        expq.push_back(ev(r+3, 2'b01, 2'b00, 2'b00, 32'd206800, 0, 0));
        expq.push_back(ev(r+4, 2'b00, 2'b01, 2'b01, 0, 32'hDEAD_BEEF, 0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        req1 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req0 = 0;

        // Reset during the third beat of a read burst
        @(posedge clk); #1;
        r = cyc;
        req0 = 1; addr0 = 32'd206800; len0 = 4'd7;
        expq.push_back(ev(r+1, 2'b01, 2'b00, 2'b00, 32'd206800, 0, 0));
        expq.push_back(ev(r+2, 2'b01, 2'b01, 2'b00, 32'd206801, 32'hDEAD_BEEF, 0));
        expq.push_back(ev(r+3, 2'b01, 2'b01, 2'b00, 32'd206802, 32'h5A00_0001, 0));
        repeat (3) @(posedge clk); #1;
        nreset = 0;
        @(posedge clk); #1;
        nreset = 1; req0 = 0;
        @(negedge clk);
        chk_all_zero("midreset");

        repeat (6) @(posedge clk);
        checks++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL missing_outputs got %0d unmatched expected entries required 0 (first cyc=%0d)",
                     expq.size(), expq[0].cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
